// File: rtl/tx_pattern_gen_pkg.sv
// Shared types and PRBS helpers for the serial TX pattern source and its RX-side checker.
package tx_pattern_gen_pkg;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_TRAIN   = 2'd1,
        TX_SYNC    = 2'd2,
        TX_PAYLOAD = 2'd3
    } tx_phase_t;

    localparam int PRBS_ORDER_7  = 32'sd7;
    localparam int PRBS_ORDER_9  = 32'sd9;
    localparam int PRBS_ORDER_15 = 32'sd15;
    localparam int PRBS_ORDER_23 = 32'sd23;
    localparam int PRBS_ORDER_31 = 32'sd31;

    // Tap mask (bit n-1 set for tap n); zero marks an unsupported order
    function automatic logic [31:0] prbs_taps(input int order);
        logic [31:0] mask_s;
        case (order)
            PRBS_ORDER_7:  mask_s = 32'h0000_0060;
            PRBS_ORDER_9:  mask_s = 32'h0000_0110;
            PRBS_ORDER_15: mask_s = 32'h0000_6000;
            PRBS_ORDER_23: mask_s = 32'h0042_0000;
            PRBS_ORDER_31: mask_s = 32'h4800_0000;
            default:       mask_s = 32'h0000_0000;
        endcase
        return mask_s;
    endfunction

    function automatic logic prbs_order_legal(input int order);
        return (prbs_taps(order) != 32'h0000_0000);
    endfunction

endpackage

// File: rtl/tx_pattern_gen_lfsr.sv
// Fibonacci PRBS generator: output is the MSB stage, new bit enters at the LSB.
module prbs_lfsr
    import tx_pattern_gen_pkg::*;
#(
    parameter int ORDER = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ORDER-1:0] seed,
    input  logic             adv,
    output logic             out
);

    localparam logic [31:0]      TAP_MASK = prbs_taps(ORDER);
    localparam logic [ORDER-1:0] TAPS     = TAP_MASK[ORDER-1:0];
    localparam logic [ORDER-1:0] ONE      = {{(ORDER-1){1'b0}}, 1'b1};
    localparam logic [ORDER-1:0] ZERO     = {ORDER{1'b0}};

    if (!prbs_order_legal(ORDER)) begin : g_bad_order
        $error("prbs_lfsr: unsupported ORDER %0d", ORDER);
    end

    logic [ORDER-1:0] lfsr_r;
    logic             fb_s;

    // Feedback bit is the XOR of the two tapped stages
    always_comb begin
        fb_s = ^(lfsr_r & TAPS);
    end

    // Load beats advance; an all-zero seed would lock up, so it becomes 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= ONE;
        end else if (load) begin
            lfsr_r <= (seed == ZERO) ? ONE : seed;
        end else if (adv) begin
            lfsr_r <= {lfsr_r[ORDER-2:0], fb_s};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign out = lfsr_r[ORDER-1];

endmodule

// File: rtl/tx_pattern_gen.sv
// Serial TX frame source: 1010 training, MSB-first sync word, then PRBS payload.
// State and counters describe the bit currently presented on data.
module tx_pattern_gen
    import tx_pattern_gen_pkg::*;
#(
    parameter int          PRBS_ORDER = 7,
    parameter int          TRAIN_LEN  = 64,
    parameter int          SYNC_LEN   = 8,
    parameter logic [31:0] SYNC_WORD  = 32'hD8,
    parameter int          LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_W-1:0]      payload_len,
    input  logic [PRBS_ORDER-1:0] seed,
    input  logic                  err_inj,
    output logic                  data,
    output logic                  valid,
    output logic [1:0]            phase,
    output logic                  busy,
    output logic                  done
);

    localparam int TRAIN_CW = (TRAIN_LEN > 0) ? $clog2(TRAIN_LEN + 1) : 1;
    localparam int SYNC_CW  = $clog2(SYNC_LEN + 1);

    localparam logic [31:0]         SYNC_ALIGNED = SYNC_WORD << (32 - SYNC_LEN);
    localparam logic [TRAIN_CW-1:0] TRAIN_LAST   = TRAIN_CW'(TRAIN_LEN);
    localparam logic [TRAIN_CW-1:0] TRAIN_ONE    = TRAIN_CW'(32'd1);
    localparam logic [TRAIN_CW-1:0] TRAIN_ZERO   = {TRAIN_CW{1'b0}};
    localparam logic [SYNC_CW-1:0]  SYNC_LAST    = SYNC_CW'(SYNC_LEN);
    localparam logic [SYNC_CW-1:0]  SYNC_ONE     = SYNC_CW'(32'd1);
    localparam logic [SYNC_CW-1:0]  SYNC_ZERO    = {SYNC_CW{1'b0}};
    localparam logic [LEN_W-1:0]    LEN_ZERO     = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]    PAY_ONE      = LEN_W'(32'd1);

    if (SYNC_LEN < 1 || SYNC_LEN > 32) begin : g_bad_sync_len
        $error("tx_pattern_gen: SYNC_LEN %0d outside 1..32", SYNC_LEN);
    end

    tx_phase_t           state_r, state_s;
    logic [TRAIN_CW-1:0] train_cnt_r, train_cnt_s;
    logic [SYNC_CW-1:0]  sync_cnt_r, sync_cnt_s;
    logic [LEN_W-1:0]    pay_cnt_r, pay_cnt_s;
    logic [LEN_W-1:0]    len_r, len_s;
    logic [31:0]         sync_sr_r, sync_sr_s;
    logic                data_r, data_s;
    logic                valid_r, valid_s;
    logic                done_r, done_s;
    logic                busy_r;
    logic                go_idle_s, enter_sync_s, emit_pay_s;
    logic                lfsr_load_s, lfsr_adv_s, lfsr_out_s;

    prbs_lfsr #(.ORDER(PRBS_ORDER)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load_s),
        .seed (seed),
        .adv  (lfsr_adv_s),
        .out  (lfsr_out_s)
    );

    // Next bit selection: phase decisions first, then the shared idle/sync/payload emit paths
    always_comb begin
        state_s      = state_r;
        train_cnt_s  = train_cnt_r;
        sync_cnt_s   = sync_cnt_r;
        pay_cnt_s    = pay_cnt_r;
        len_s        = len_r;
        sync_sr_s    = sync_sr_r;
        data_s       = data_r;
        valid_s      = 1'b0;
        done_s       = 1'b0;
        go_idle_s    = 1'b0;
        enter_sync_s = 1'b0;
        emit_pay_s   = 1'b0;
        lfsr_load_s  = 1'b0;
        lfsr_adv_s   = 1'b0;

        if (abort) begin
            go_idle_s = 1'b1;
        end else if (en) begin
            case (state_r)
                TX_IDLE: begin
                    if (start) begin
                        len_s       = payload_len;
                        lfsr_load_s = 1'b1;
                        sync_sr_s   = SYNC_ALIGNED;
                        if (TRAIN_LEN > 0) begin
                            state_s     = TX_TRAIN;
                            train_cnt_s = TRAIN_ONE;
                            data_s      = 1'b1;
                            valid_s     = 1'b1;
                        end else begin
                            enter_sync_s = 1'b1;
                        end
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end
                TX_TRAIN: begin
                    if (train_cnt_r == TRAIN_LAST) begin
                        enter_sync_s = 1'b1;
                    end else begin
                        data_s      = ~train_cnt_r[0];
                        train_cnt_s = train_cnt_r + TRAIN_ONE;
                        valid_s     = 1'b1;
                    end
                end
                TX_SYNC: begin
                    if (sync_cnt_r == SYNC_LAST) begin
                        if (len_r == LEN_ZERO) begin
                            go_idle_s = 1'b1;
                        end else begin
                            emit_pay_s = 1'b1;
                        end
                    end else begin
                        data_s     = sync_sr_r[31];
                        sync_sr_s  = {sync_sr_r[30:0], 1'b0};
                        sync_cnt_s = sync_cnt_r + SYNC_ONE;
                        valid_s    = 1'b1;
                        done_s     = (sync_cnt_s == SYNC_LAST) && (len_r == LEN_ZERO);
                    end
                end
                TX_PAYLOAD: begin
                    if (pay_cnt_r == len_r) begin
                        go_idle_s = 1'b1;
                    end else begin
                        emit_pay_s = 1'b1;
                    end
                end
                default: begin
                    go_idle_s = 1'b1;
                end
            endcase
        end else begin
            valid_s = 1'b0;
        end

        if (go_idle_s) begin
            state_s     = TX_IDLE;
            train_cnt_s = TRAIN_ZERO;
            sync_cnt_s  = SYNC_ZERO;
            pay_cnt_s   = LEN_ZERO;
            data_s      = 1'b0;
            valid_s     = 1'b0;
            done_s      = 1'b0;
        end else if (enter_sync_s) begin
            state_s    = TX_SYNC;
            data_s     = sync_sr_s[31];
            sync_sr_s  = {sync_sr_s[30:0], 1'b0};
            sync_cnt_s = SYNC_ONE;
            valid_s    = 1'b1;
            done_s     = (SYNC_LAST == SYNC_ONE) && (len_s == LEN_ZERO);
        end else if (emit_pay_s) begin
            // err_inj flips only the transmitted copy; the LFSR keeps the true sequence
            state_s    = TX_PAYLOAD;
            data_s     = lfsr_out_s ^ err_inj;
            lfsr_adv_s = 1'b1;
            pay_cnt_s  = pay_cnt_r + PAY_ONE;
            valid_s    = 1'b1;
            done_s     = (pay_cnt_s == len_r);
        end else begin
            lfsr_adv_s = 1'b0;
        end
    end

    // State, counters and the registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= TX_IDLE;
            train_cnt_r <= TRAIN_ZERO;
            sync_cnt_r  <= SYNC_ZERO;
            pay_cnt_r   <= LEN_ZERO;
            len_r       <= LEN_ZERO;
            sync_sr_r   <= 32'h0000_0000;
            data_r      <= 1'b0;
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            train_cnt_r <= train_cnt_s;
            sync_cnt_r  <= sync_cnt_s;
            pay_cnt_r   <= pay_cnt_s;
            len_r       <= len_s;
            sync_sr_r   <= sync_sr_s;
            data_r      <= data_s;
            valid_r     <= valid_s;
            done_r      <= done_s;
            busy_r      <= (state_s != TX_IDLE);
        end
    end

    assign data  = data_r;
    assign valid = valid_r;
    assign phase = state_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Randomised bench for tx_pattern_gen against a queue-based frame model.
module tb_tx_pattern_gen;

    localparam int          TRAIN_LEN = 4;
    localparam int          SYNC_LEN  = 8;
    localparam logic [31:0] SYNC_WORD = 32'hD8;
    localparam int          HDR       = TRAIN_LEN + SYNC_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, start = 1'b0, abort = 1'b0, err_inj = 1'b0;
    logic [15:0] payload_len = 16'd0;
    logic [6:0]  seed = 7'd1;
    logic        data, valid, busy, done;
    logic [1:0]  phase;

    tx_pattern_gen #(
        .PRBS_ORDER(7), .TRAIN_LEN(TRAIN_LEN), .SYNC_LEN(SYNC_LEN),
        .SYNC_WORD(SYNC_WORD), .LEN_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
        .payload_len(payload_len), .seed(seed), .err_inj(err_inj),
        .data(data), .valid(valid), .phase(phase), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Frame builder straight from the frame definition
    bit         fb_q[$];
    logic [1:0] fp_q[$];

    task automatic make_frame(input int len, input int sd);
        int s, fbk;
        fb_q.delete();
        fp_q.delete();
        for (int i = 0; i < TRAIN_LEN; i++) begin
            fb_q.push_back(bit'((i % 2) == 0));
            fp_q.push_back(2'd1);
        end
        for (int i = SYNC_LEN - 1; i >= 0; i--) begin
            fb_q.push_back(SYNC_WORD[i]);
            fp_q.push_back(2'd2);
        end
        s = (sd == 0) ? 1 : sd;
        for (int i = 0; i < len; i++) begin
            fb_q.push_back(bit'((s >> 6) & 1));
            fp_q.push_back(2'd3);
            fbk = ((s >> 6) ^ (s >> 5)) & 1;
            s = ((s << 1) | fbk) & 127;
        end
    endtask

    // Reference model state: remaining bits of the frame plus expected outputs
    bit         exp_q[$];
    logic [1:0] exp_pq[$];
    int         exp_total = 0;
    bit         in_frame  = 1'b0;
    logic       exp_data = 1'b0, exp_valid = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
    logic [1:0] exp_phase = 2'd0;

    task automatic model_idle();
        in_frame = 1'b0;
        exp_q.delete();
        exp_pq.delete();
        exp_data = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; exp_phase = 2'd0;
    endtask

    task automatic model_pop();
        bit b;
        logic [1:0] p;
        b = exp_q.pop_front();
        p = exp_pq.pop_front();
        if (p == 2'd3 && err_inj) b = ~b;
        exp_data = b; exp_phase = p; exp_valid = 1'b1;
        exp_done = (exp_q.size() == 0);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_idle();
            else if (abort) model_idle();
            else if (!en) begin
                exp_valid = 1'b0; exp_done = 1'b0;
            end else if (in_frame) begin
                if (exp_q.size() > 0) model_pop();
                else model_idle();
            end else if (start) begin
                make_frame(int'(payload_len), int'(seed));
                exp_q = fb_q; exp_pq = fp_q; exp_total = fb_q.size();
                in_frame = 1'b1;
                model_pop();
            end else model_idle();
            exp_busy = in_frame;
        end
    end

    // Every-cycle comparison plus capture of the presented bit stream
    bit         cap_q[$];
    logic [1:0] capp_q[$];
    int         done_cnt = 0;
    int         done_idx = -1;

    initial begin
        forever begin
            @(negedge clk);
            check("valid", valid, exp_valid);
            check("busy",  busy,  exp_busy);
            check("done",  done,  exp_done);
            check("phase", phase, exp_phase);
            check("data",  data,  exp_data);
            if (valid) begin
                cap_q.push_back(data);
                capp_q.push_back(phase);
            end
            if (done) begin
                done_cnt++;
                done_idx = cap_q.size();
            end
        end
    end

    task automatic run_frame(input int len, input int sd, input int en_mode,
                             input int err_bit, input int abort_mode);
        int cyc, idx;
        bit en_tog, aborted;
        cap_q.delete(); capp_q.delete(); done_idx = -1;
        @(negedge clk);
        start = 1'b1; en = 1'b1; abort = 1'b0; err_inj = 1'b0;
        payload_len = 16'(len); seed = 7'(sd);
        en_tog = 1'b0; aborted = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            if (!in_frame) break;
            cyc++;
            if (cyc > 4 * (len + HDR) + 100) begin
                check("frame_timeout", 32'd0, 32'd1);
                break;
            end
            start = (en_mode == 2) ? ($urandom_range(0, 4) == 0) : 1'b0;
            case (en_mode)
                0: en = 1'b1;
                1: begin en = en_tog; en_tog = ~en_tog; end
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            idx = exp_total - exp_q.size() - HDR;
            if (en_mode == 2) err_inj = ($urandom_range(0, 9) == 0);
            else err_inj = en && (idx == err_bit);
            case (abort_mode)
                1: abort = !aborted && (exp_phase == 2'd2);
                2: abort = ($urandom_range(0, 29) == 0);
                default: abort = 1'b0;
            endcase
            if (abort) aborted = 1'b1;
        end
        start = 1'b0; en = 1'b1; abort = 1'b0; err_inj = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit [18:0] lit;
        int mism, ones, d0, wait_c;

        repeat (3) @(negedge clk);
        check("reset_data",  data,  1'b0);
        check("reset_valid", valid, 1'b0);
        check("reset_busy",  busy,  1'b0);
        check("reset_phase", phase, 2'd0);
        rst = 1'b0;
        en = 1'b1;
        repeat (2) @(negedge clk);

        // Pin the model itself against the hand-written frame
        lit = 19'b1010110110000000001;
        make_frame(7, 1);
        mism = 0;
        for (int i = 0; i < 19; i++) begin
            if (fb_q[i] != lit[18 - i]) mism++;
            if (fp_q[i] != ((i < 4) ? 2'd1 : (i < 12) ? 2'd2 : 2'd3)) mism++;
        end
        check("model_pin_frame", mism, 32'd0);
        check("model_pin_len", fb_q.size(), 32'd19);

        // Basic frame with en held high
        run_frame(7, 1, 0, -1, 0);
        mism = 0;
        for (int i = 0; i < 19 && i < cap_q.size(); i++)
            if (cap_q[i] != lit[18 - i]) mism++;
        check("t2_bits", mism, 32'd0);
        check("t2_count", cap_q.size(), 32'd19);
        check("t2_done_pos", done_idx, 32'd19);

        // PRBS7 period and balance
        run_frame(254, 1, 0, -1, 0);
        check("t3_count", cap_q.size(), 32'(HDR + 254));
        mism = 0; ones = 0;
        if (cap_q.size() == HDR + 254) begin
            for (int i = 0; i < 127; i++) begin
                if (cap_q[HDR + i] != cap_q[HDR + i + 127]) mism++;
                if (cap_q[HDR + i]) ones++;
            end
        end
        check("t3_period", mism, 32'd0);
        check("t3_ones", ones, 32'd64);

        // Stalls every other UI give the same bits
        run_frame(7, 5, 1, -1, 0);
        make_frame(7, 5);
        mism = 0;
        for (int i = 0; i < fb_q.size() && i < cap_q.size(); i++)
            if (cap_q[i] != fb_q[i]) mism++;
        check("t4_bits", mism, 32'd0);
        check("t4_count", cap_q.size(), 32'd19);

        // Single injected error at payload bit 10
        run_frame(20, 7'h35, 0, 10, 0);
        make_frame(20, 7'h35);
        mism = 0;
        for (int i = 0; i < fb_q.size() && i < cap_q.size(); i++)
            if (cap_q[i] != fb_q[i]) mism++;
        check("t5_diff_count", mism, 32'd1);
        check("t5_diff_pos", (cap_q.size() > HDR + 10) ? 32'(cap_q[HDR + 10] != fb_q[HDR + 10]) : 32'd0, 32'd1);

        // Empty payload ends on the last sync bit
        run_frame(0, 3, 0, -1, 0);
        check("t6_len0_count", cap_q.size(), 32'(HDR));
        check("t6_len0_done", done_idx, 32'(HDR));

        // Abort during SYNC: back to idle, no done
        d0 = done_cnt;
        run_frame(10, 9, 0, -1, 1);
        check("t6_abort_bits", cap_q.size(), 32'(TRAIN_LEN + 1));
        check("t6_abort_nodone", done_cnt, 32'(d0));

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t6_start_abort_busy", busy, 1'b0);
        check("t6_start_abort_valid", valid, 1'b0);

        // Asynchronous reset in the middle of the payload
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; payload_len = 16'd30; seed = 7'd17;
        @(negedge clk);
        start = 1'b0;
        wait_c = 0;
        while (exp_phase != 2'd3 && wait_c < 200) begin
            @(negedge clk);
            wait_c++;
        end
        check("t1_reached_payload", exp_phase, 2'd3);
        #2 rst = 1'b1;
        #1;
        check("t1_data",  data,  1'b0);
        check("t1_valid", valid, 1'b0);
        check("t1_phase", phase, 2'd0);
        check("t1_busy",  busy,  1'b0);
        check("t1_done",  done,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_nodone", done_cnt, 32'(d0));

        // Random frames with stalls, stray starts, error injection and aborts
        for (int f = 0; f < 25; f++)
            run_frame($urandom_range(0, 40), $urandom_range(0, 127), 2, -1,
                      (f % 3 == 0) ? 2 : 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
